alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the ALU: accepts decoded ops, resolves operands, and presents registered A, B, CTL and RD to the ALU.
- Source resolution: register-file value, immediate, or a forwarded execute/writeback result.
- Two-entry skid buffer: upstream sees a registered ready, and downstream backpressure never drops or duplicates an op.

---
 rtl/alu_operand_stage_pkg.sv | 38 +++
 rtl/alu_operand_skid.sv | 80 ++++++++
 rtl/alu_operand_stage.sv | 133 +++++++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
//============================================================================
// alu_operand_stage_pkg : shared ALU command codes and operand entry record
// Revision: 1.0
//============================================================================
`default_nettype none

package alu_operand_stage_pkg;

    localparam int CBITS       = 4;
    localparam int ENTRY_BITS  = 32;
    localparam int ENTRY_RBITS = 4;

    typedef enum logic [CBITS-1:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_LT   = 4'd2,
        CMD_LE   = 4'd3,
        CMD_AND  = 4'd4,
        CMD_OR   = 4'd5,
        CMD_XOR  = 4'd6,
        CMD_NAND = 4'd7,
        CMD_NOR  = 4'd8,
        CMD_NXOR = 4'd9
    } alu_cmd_e;

    typedef struct packed {
        logic [CBITS-1:0]       ctl;
        logic [ENTRY_RBITS-1:0] rd;
        logic [ENTRY_RBITS-1:0] rs1;
        logic [ENTRY_RBITS-1:0] rs2;
        logic                   useimm;
        logic [ENTRY_BITS-1:0]  a;
        logic [ENTRY_BITS-1:0]  b;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_operand_skid.sv
//============================================================================
// alu_operand_skid : two-entry valid/ready skid buffer with held-entry update
// Revision: 1.0
//============================================================================
`default_nettype none

import alu_operand_stage_pkg::*;

module alu_operand_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_main,
    output logic [W-1:0] o_skid,
    input  logic [W-1:0] i_main_upd,
    input  logic [W-1:0] i_skid_upd
);

    logic         r_main_vld;
    logic         r_skid_vld;
    logic         r_in_ready;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;

    logic w_in_acc;
    logic w_out_acc;
    logic w_main_free;
    logic w_main_vld_nxt;
    logic w_skid_vld_nxt;

    assign w_in_acc    = i_in_valid & r_in_ready;
    assign w_out_acc   = r_main_vld & i_out_ready;
    assign w_main_free = ~r_main_vld | w_out_acc;

    // r_in_ready mirrors the next skid state, so the skid never holds while ready is high.
    assign w_main_vld_nxt = w_main_free ? (r_skid_vld | w_in_acc) : 1'b1;
    assign w_skid_vld_nxt = w_main_free ? 1'b0 : (r_skid_vld | w_in_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_in_ready <= ~w_skid_vld_nxt;
            if (w_main_free) begin
                if (r_skid_vld) begin
                    r_main <= i_skid_upd;
                end else if (w_in_acc) begin
                    r_main <= i_in_data;
                end
            end else begin
                r_main <= i_main_upd;
                if (w_in_acc) begin
                    r_skid <= i_in_data;
                end else if (r_skid_vld) begin
                    r_skid <= i_skid_upd;
                end
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_main_vld;
    assign o_main      = r_main;
    assign o_skid      = r_skid;

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
//============================================================================
// alu_operand_stage : resolves ALU operands and registers them through a skid
// buffer. Optional forwarding: define ALU_OPERAND_FWD_EN.  Revision: 1.0
//============================================================================
`default_nettype none

import alu_operand_stage_pkg::*;

module alu_operand_stage #(
    parameter int BITS  = ENTRY_BITS,
    parameter int CBITS = alu_operand_stage_pkg::CBITS,
    parameter int RBITS = ENTRY_RBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CBITS-1:0] in_ctl,
    input  logic [RBITS-1:0] in_rs1,
    input  logic [RBITS-1:0] in_rs2,
    input  logic [RBITS-1:0] in_rd,
    input  logic [BITS-1:0]  in_rf1,
    input  logic [BITS-1:0]  in_rf2,
    input  logic [BITS-1:0]  in_imm,
    input  logic             in_useimm,
    input  logic             ex_we,
    input  logic [RBITS-1:0] ex_rd,
    input  logic [BITS-1:0]  ex_data,
    input  logic             wb_we,
    input  logic [RBITS-1:0] wb_rd,
    input  logic [BITS-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  a,
    output logic [BITS-1:0]  b,
    output logic [CBITS-1:0] ctl,
    output logic [RBITS-1:0] rd
);

    typedef struct packed {
        logic [CBITS-1:0] ctl;
        logic [RBITS-1:0] rd;
        logic [RBITS-1:0] rs1;
        logic [RBITS-1:0] rs2;
        logic             useimm;
        logic [BITS-1:0]  a;
        logic [BITS-1:0]  b;
    } stage_entry_t;

    localparam int C_EW = $bits(stage_entry_t);

    stage_entry_t w_new;
    stage_entry_t w_main;
    stage_entry_t w_skid;
    stage_entry_t w_main_upd;
    stage_entry_t w_skid_upd;
    logic         w_unused;

    always_comb begin
        w_new        = '0;
        w_new.ctl    = in_ctl;
        w_new.rd     = in_rd;
        w_new.useimm = in_useimm;
`ifdef ALU_OPERAND_FWD_EN
        w_new.rs1 = in_rs1;
        // An immediate B carries no tag, so held re-resolve can never touch it.
        w_new.rs2 = in_useimm ? '0 : in_rs2;
        if (in_rs1 == '0)
            w_new.a = '0;
        else if (ex_we && (ex_rd == in_rs1))
            w_new.a = ex_data;
        else if (wb_we && (wb_rd == in_rs1))
            w_new.a = wb_data;
        else
            w_new.a = in_rf1;
        if (in_useimm)
            w_new.b = in_imm;
        else if (in_rs2 == '0)
            w_new.b = '0;
        else if (ex_we && (ex_rd == in_rs2))
            w_new.b = ex_data;
        else if (wb_we && (wb_rd == in_rs2))
            w_new.b = wb_data;
        else
            w_new.b = in_rf2;
`else
        w_new.a = (in_rs1 == '0) ? '0 : in_rf1;
        w_new.b = in_useimm ? in_imm : ((in_rs2 == '0) ? '0 : in_rf2);
`endif
    end

`ifdef ALU_OPERAND_FWD_EN
    always_comb begin
        w_main_upd = w_main;
        w_skid_upd = w_skid;
        if (wb_we && (w_main.rs1 != '0) && (wb_rd == w_main.rs1)) w_main_upd.a = wb_data;
        if (wb_we && (w_main.rs2 != '0) && (wb_rd == w_main.rs2)) w_main_upd.b = wb_data;
        if (wb_we && (w_skid.rs1 != '0) && (wb_rd == w_skid.rs1)) w_skid_upd.a = wb_data;
        if (wb_we && (w_skid.rs2 != '0) && (wb_rd == w_skid.rs2)) w_skid_upd.b = wb_data;
    end

    assign w_unused = w_main.useimm ^ w_skid.useimm;
`else
    assign w_main_upd = w_main;
    assign w_skid_upd = w_skid;
    assign w_unused   = ^{ex_we, ex_rd, ex_data, wb_we, wb_rd, wb_data,
                          w_main.rs1, w_main.rs2, w_main.useimm};
`endif

    alu_operand_skid #(
        .W (C_EW)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (w_new),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_main      (w_main),
        .o_skid      (w_skid),
        .i_main_upd  (w_main_upd),
        .i_skid_upd  (w_skid_upd)
    );

    assign a   = w_main.a;
    assign b   = w_main.b;
    assign ctl = w_main.ctl;
    assign rd  = w_main.rd;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
//============================================================================
// tb_alu_operand_stage : directed self-checking bench for alu_operand_stage
// Revision: 1.0
//============================================================================
`default_nettype none

import alu_operand_stage_pkg::*;

module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctl;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  in_rd;
    logic [31:0] in_rf1;
    logic [31:0] in_rf2;
    logic [31:0] in_imm;
    logic        in_useimm;
    logic        ex_we;
    logic [3:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [3:0]  rd;

    int total = 0;
    int bad   = 0;

    alu_operand_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctl    (in_ctl),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rf1    (in_rf1),
        .in_rf2    (in_rf2),
        .in_imm    (in_imm),
        .in_useimm (in_useimm),
        .ex_we     (ex_we),
        .ex_rd     (ex_rd),
        .ex_data   (ex_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ctl       (ctl),
        .rd        (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] d, input logic [31:0] f1,
                         input logic [31:0] f2, input logic [31:0] im, input logic ui);
        in_valid  = v;
        in_ctl    = c;
        in_rs1    = r1;
        in_rs2    = r2;
        in_rd     = d;
        in_rf1    = f1;
        in_rf2    = f2;
        in_imm    = im;
        in_useimm = ui;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        ex_we = 1'b0; ex_rd = 4'd0; ex_data = 32'd0;
        wb_we = 1'b0; wb_rd = 4'd0; wb_data = 32'd0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);

        // reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_a",   a,          32'd0);
        check("rst_b",   b,          32'd0);
        check("rst_ctl", 32'(ctl),   32'd0);
        check("rst_rd",  32'(rd),    32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // back-to-back ADD then SUB
        drive(1'b1, CMD_ADD, 4'd1, 4'd2, 4'd3, 32'd5, 32'd7, 32'd0, 1'b0);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a",     a,              32'd5);
        check("add_b",     b,              32'd7);
        check("add_ctl",   32'(ctl),       32'(CMD_ADD));
        check("add_rd",    32'(rd),        32'd3);
        check("add_ready", 32'(in_ready),  32'd1);
        drive(1'b1, CMD_SUB, 4'd1, 4'd2, 4'd5, 32'd9, 32'd4, 32'd0, 1'b0);
        @(negedge clk);
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_a",     a,              32'd9);
        check("sub_b",     b,              32'd4);
        check("sub_ctl",   32'(ctl),       32'(CMD_SUB));
        check("sub_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd0);

        // EX beats WB, then WB alone
        ex_we = 1'b1; ex_rd = 4'd3; ex_data = 32'h10;
        wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'h20;
        drive(1'b1, CMD_ADD, 4'd3, 4'd5, 4'd1, 32'h33, 32'h55, 32'd0, 1'b0);
        @(negedge clk);
        check("fwd_ex_a", a, FWD ? 32'h10 : 32'h33);
        check("fwd_ex_b", b, 32'h55);
        ex_we = 1'b0;
        drive(1'b1, CMD_OR, 4'd3, 4'd5, 4'd1, 32'h33, 32'h55, 32'd0, 1'b0);
        @(negedge clk);
        check("fwd_wb_a", a, FWD ? 32'h20 : 32'h33);
        check("fwd_wb_ctl", 32'(ctl), 32'(CMD_OR));

        // register 0 never forwards
        ex_we = 1'b1; ex_rd = 4'd0; ex_data = 32'hFF; wb_we = 1'b0;
        drive(1'b1, 4'd15, 4'd0, 4'd5, 4'd2, 32'h77, 32'h55, 32'd0, 1'b0);
        @(negedge clk);
        check("r0_a",   a,        32'd0);
        check("r0_ctl", 32'(ctl), 32'd15);
        in_valid = 1'b0; ex_we = 1'b0;
        @(negedge clk);

        // backpressure: two ops accepted, third held off
        out_ready = 1'b0;
        drive(1'b1, CMD_AND, 4'd1, 4'd2, 4'd1, 32'h11, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("bp1_ready", 32'(in_ready), 32'd1);
        check("bp1_rd",    32'(rd),       32'd1);
        drive(1'b1, CMD_AND, 4'd1, 4'd2, 4'd2, 32'h22, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("bp2_ready", 32'(in_ready), 32'd0);
        check("bp2_a",     a,             32'h11);
        drive(1'b1, CMD_AND, 4'd1, 4'd2, 4'd3, 32'h33, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("bp3_ready", 32'(in_ready), 32'd0);
        check("bp3_rd",    32'(rd),       32'd1);
        check("bp3_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out2_rd",    32'(rd),       32'd2);
        check("bp_out2_a",     a,             32'h22);
        check("bp_out2_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_out3_rd",    32'(rd),       32'd3);
        check("bp_out3_a",     a,             32'h33);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // WB update of a stalled register operand
        out_ready = 1'b0;
        drive(1'b1, CMD_XOR, 4'd1, 4'd4, 4'd6, 32'h11, 32'h44, 32'h1234, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_b0", b, 32'h44);
        wb_we = 1'b1; wb_rd = 4'd4; wb_data = 32'h99;
        @(negedge clk);
        check("stall_b_wb", b, FWD ? 32'h99 : 32'h44);
        check("stall_a_wb", a, 32'h11);
        wb_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("stall_drain", 32'(out_valid), 32'd0);

        // immediate B ignores WB
        out_ready = 1'b0;
        drive(1'b1, CMD_NOR, 4'd1, 4'd4, 4'd7, 32'h11, 32'h44, 32'h1234, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("imm_b0", b, 32'h1234);
        wb_we = 1'b1; wb_rd = 4'd4; wb_data = 32'h99;
        @(negedge clk);
        check("imm_b_wb", b, 32'h1234);
        wb_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // reset with skid full
        out_ready = 1'b0;
        drive(1'b1, CMD_LT, 4'd1, 4'd2, 4'd7, 32'hA1, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, CMD_LE, 4'd1, 4'd2, 4'd8, 32'hA2, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_a",     a,             32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
